// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Run-time controller for a toggle-type clock divider. clkout = clk/(2*half_r).
//   Start/stop and ratio changes are sequenced so clkout never has a runt pulse:
//   a new ratio takes effect at a falling clkout edge, and a disable that arrives
//   during the high phase lets that phase finish before going idle.
// Ports
//   clk        in   input clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   divider enable (level)
//   cfg_valid  in   new half-period offered
//   cfg_half   in   requested half-period in clk cycles (0 is illegal)
//   cfg_ready  out  controller can accept cfg this cycle (decoded from state)
//   cfg_err    out  1-cycle pulse: accepted cfg had cfg_half==0 and was dropped
//   clkout     out  divided clock (registered)
//   busy       out  state != IDLE
module clk_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clkout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clkout_q, clkout_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_xfer;
    logic             cfg_ok;
    logic             tog;
    logic             fall;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clk_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= CNT_W'(DEF_HALF);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clkout_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clkout_q   <= clkout_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // half_q is never 0 (zero requests are rejected), so half_q-1 cannot wrap
    // and cnt stays within 0..half_q-1.
    assign cfg_xfer = cfg_valid && cfg_ready;
    assign cfg_ok   = cfg_xfer && (cfg_half != '0);
    assign tog      = (cnt_q == half_q - CNT_W'(1));
    assign fall     = tog && clkout_q;
    assign cnt_nxt  = tog ? '0 : cnt_q + CNT_W'(1);
    assign clk_nxt  = tog ? ~clkout_q : clkout_q;

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clkout_d   = clkout_q;
        cfg_err_d  = cfg_xfer && (cfg_half == '0);

        unique case (state_q)
            IDLE: begin
                clkout_d = 1'b0;
                cnt_d    = '0;
                // Ratio applies at once so a same-edge enable starts on it.
                if (cfg_ok) half_d = cfg_half;
                if (en)     state_d = RUN;
            end
            RUN: begin
                if (!en && (!clkout_q || fall)) begin
                    // Low phase (or the edge that ends the high phase): stop
                    // without a glitch; clkout is already/now low.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    clkout_d = 1'b0;
                    if (cfg_ok) half_d = cfg_half;
                end else begin
                    cnt_d    = cnt_nxt;
                    clkout_d = clk_nxt;
                    if (cfg_ok) begin
                        pend_d     = cfg_half;
                        pend_vld_d = 1'b1;
                    end
                    if (!en)         state_d = STOP;
                    else if (cfg_ok) state_d = PEND;
                end
            end
            PEND: begin
                if ((!en && !clkout_q) || fall) begin
                    // Ratio swap at the fall: following low phase uses new half.
                    state_d    = en ? RUN : IDLE;
                    half_d     = pend_q;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    clkout_d   = 1'b0;
                end else begin
                    cnt_d    = cnt_nxt;
                    clkout_d = clk_nxt;
                    if (!en) state_d = STOP;
                end
            end
            STOP: begin
                // Only entered with clkout high, so the next toggle is the fall.
                if (fall) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    clkout_d   = 1'b0;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) half_d = pend_q;
                end else begin
                    cnt_d    = cnt_nxt;
                    clkout_d = clk_nxt;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: registered or decoded from state only
    always_comb begin
        cfg_ready = (state_q == IDLE) || (state_q == RUN);
        busy      = (state_q != IDLE);
        cfg_err   = cfg_err_q;
        clkout    = clkout_q;
    end

endmodule
